mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port data memory (`mem`, 32-bit words, 4-bit byte write mask, synchronous write, combinational read) between the multicycle CPU (`riscvmulti`, port 0) and a debug/program-loader master (port 1). It sits between both masters and the memory.
- Arbitration is round-robin with an optional bounded lock for atomic multi-access sequences.
- Every accepted access takes one memory cycle and produces a registered response one cycle later.

---
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter with a bounded lock that shares one
// single-port data memory between the CPU (port 0) and a debug/loader
// master (port 1). Each granted access produces a one-cycle registered response.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   reqN, weN, addrN, wdataN,
//   wmaskN, lockN              master N request and attributes (N = 0, 1)
//   gntN                       access accepted this cycle (combinational)
//   rvalidN                    response pulse, one cycle after the grant
//   rdata                      registered read data, shared by both ports
//   mem_we, mem_addr,
//   mem_wdata, mem_wmask       memory request bus (combinational)
//   mem_rdata                  combinational read data from memory
module mem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_LOCK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0,
    input  logic            we0,
    input  logic [AW-1:0]   addr0,
    input  logic [DW-1:0]   wdata0,
    input  logic [DW/8-1:0] wmask0,
    input  logic            lock0,
    input  logic            req1,
    input  logic            we1,
    input  logic [AW-1:0]   addr1,
    input  logic [DW-1:0]   wdata1,
    input  logic [DW/8-1:0] wmask1,
    input  logic            lock1,
    output logic            gnt0,
    output logic            gnt1,
    output logic            rvalid0,
    output logic            rvalid1,
    output logic [DW-1:0]   rdata,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int unsigned MW = DW / 8;
    localparam int unsigned CW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    owner_e          owner_q, owner_d;
    logic            prio_q, prio_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            rvalid0_q, rvalid0_d;
    logic            rvalid1_q, rvalid1_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            any_gnt_c;
    logic            sel_we_c;
    logic            sel_lock_c;

    // Port selection: an owner excludes the other port even while idle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            unique case (owner_q)
                OWN_P0: gnt0 = req0;
                OWN_P1: gnt1 = req1;
                default: begin
                    if (req0 && req1) begin
                        gnt0 = ~prio_q;
                        gnt1 = prio_q;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
            endcase
        end
    end

    // Memory bus mux; idle cycles leave port 0 on the address/data lines.
    always_comb begin
        any_gnt_c  = gnt0 | gnt1;
        sel_we_c   = gnt1 ? we1 : we0;
        sel_lock_c = gnt1 ? lock1 : lock0;
        mem_addr   = gnt1 ? addr1 : addr0;
        mem_wdata  = gnt1 ? wdata1 : wdata0;
        mem_we     = any_gnt_c & sel_we_c;
        mem_wmask  = any_gnt_c ? (gnt1 ? wmask1 : wmask0) : MW'(0);
    end

    // Next-state: priority flip, lock ownership/count and response capture.
    always_comb begin
        prio_d     = prio_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        rvalid0_d  = gnt0;
        rvalid1_d  = gnt1;
        rdata_d    = rdata_q;
        if (any_gnt_c) begin
            prio_d = gnt0;
            if (!sel_we_c) begin
                rdata_d = mem_rdata;
            end
            // Release on an unlocked grant or once the locked run hits MAX_LOCK.
            if (sel_lock_c && (owner_q == OWN_NONE || lock_cnt_q < CW'(MAX_LOCK - 1))) begin
                owner_d    = gnt1 ? OWN_P1 : OWN_P0;
                lock_cnt_d = lock_cnt_q + CW'(1);
            end else begin
                owner_d    = OWN_NONE;
                lock_cnt_d = CW'(0);
            end
        end
    end

    // State and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q     <= 1'b0;
            owner_q    <= OWN_NONE;
            lock_cnt_q <= CW'(0);
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= DW'(0);
        end else begin
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a behavioural model of the arbiter and RAM.
module tb_mem_arbiter;

    localparam int ML = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [3:0]  wmask0, wmask1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    logic [31:0] ram   [64];
    logic [31:0] m_mem [64];

    int          m_prio, m_owner, m_streak, m_rv, last_g;
    logic [31:0] m_rdata;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(ML)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .wmask0(wmask0), .lock0(lock0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .wmask1(wmask1), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Memory: combinational read, byte-masked synchronous write.
    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= merge(ram[mem_addr[7:2]], mem_wdata, mem_wmask);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_prio = 0; m_owner = -1; m_streak = 0; m_rv = -1; m_rdata = '0;
    endtask

    // Which port the rules select this cycle (-1 = none).
    function automatic int pick();
        if (m_owner == 0) return req0 ? 0 : -1;
        if (m_owner == 1) return req1 ? 1 : -1;
        if (req0 && req1) return m_prio;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    task automatic model_commit(input int g);
        logic [31:0] a, d;
        logic [3:0]  m;
        logic        w, lk;
        m_rv = g;
        if (g < 0) return;
        a  = (g == 1) ? addr1 : addr0;
        d  = (g == 1) ? wdata1 : wdata0;
        m  = (g == 1) ? wmask1 : wmask0;
        w  = (g == 1) ? we1 : we0;
        lk = (g == 1) ? lock1 : lock0;
        if (w) m_mem[a[7:2]] = merge(m_mem[a[7:2]], d, m);
        else   m_rdata = m_mem[a[7:2]];
        m_prio = 1 - g;
        // A locked run may last at most ML grants in a row.
        if (lk && m_streak + 1 < ML) begin
            m_owner  = g;
            m_streak = m_streak + 1;
        end else begin
            m_owner  = -1;
            m_streak = 0;
        end
    endtask

    // One cycle: entered at a negedge with inputs already driven.
    task automatic step();
        int g;
        #1;
        g = pick();
        check("gnt0", gnt0, g == 0);
        check("gnt1", gnt1, g == 1);
        check("mem_we", mem_we, (g == 0) ? we0 : (g == 1) ? we1 : 1'b0);
        check("mem_wmask", mem_wmask, (g == 0) ? wmask0 : (g == 1) ? wmask1 : 4'h0);
        if (g >= 0) begin
            check("mem_addr", mem_addr, (g == 1) ? addr1 : addr0);
            check("mem_wdata", mem_wdata, (g == 1) ? wdata1 : wdata0);
        end
        last_g = g;
        model_commit(g);
        @(posedge clk);
        #1;
        check("rvalid0", rvalid0, m_rv == 0);
        check("rvalid1", rvalid1, m_rv == 1);
        check("rdata", rdata, m_rdata);
        @(negedge clk);
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m, input logic l);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; wmask0 = m; lock0 = l; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; wmask1 = m; lock1 = l; end
    endtask

    task automatic new_req(input int p);
        logic r, w, l;
        logic [31:0] a, d;
        logic [3:0]  m;
        r = ($urandom_range(2) != 0);
        w = 1'($urandom_range(1));
        l = ($urandom_range(2) == 0);
        a = $urandom;
        d = $urandom;
        m = 4'($urandom);
        drive(p, r, w, a, d, m, l);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i]   = $urandom;
            m_mem[i] = ram[i];
        end
        ram[16]   = 32'hDEADBEEF;
        m_mem[16] = 32'hDEADBEEF;
        model_reset();
        last_g = -1;
        reset = 1'b1;
        drive(0, 1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // Held in reset with a write pending: nothing may be granted.
        repeat (2) @(negedge clk);
        #1;
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_wmask", mem_wmask, 4'h0);
        check("rst_rvalid0", rvalid0, 1'b0);
        check("rst_rvalid1", rvalid1, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        reset = 1'b0;

        // Single read on idle.
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
        step();
        check("read_gnt", last_g, 0);
        check("read_data", rdata, 32'hDEADBEEF);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // Byte write then read-back from port 1.
        drive(1, 1'b1, 1'b1, 32'h40, 32'h0000_00AB, 4'b0001, 1'b0);
        step();
        check("bw_gnt", last_g, 1);
        drive(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
        step();
        check("bw_readback", rdata, 32'hDEADBEAB);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // Contention, no lock: alternates starting at port 0.
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("contend_order", last_g, i % 2);
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // Make port 1 preferred, then it locks for ML grants before port 0 gets in.
        step();
        drive(1, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0, 1'b1);
        for (int i = 0; i < ML; i++) begin
            step();
            check("lock_run", last_g, 1);
        end
        step();
        check("lock_release", last_g, 0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // Idle owner blocks the other port until an unlocked grant releases.
        drive(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1);
        step();
        check("own_take", last_g, 0);
        drive(0, 1'b0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1);
        drive(1, 1'b1, 1'b1, 32'h44, 32'h5555_AAAA, 4'hF, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("own_block", last_g, -1);
        end
        drive(0, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0);
        step();
        check("own_free", last_g, 0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        step();
        check("own_after", last_g, 1);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // Random traffic; a pending request keeps its attributes until granted.
        for (int c = 0; c < 400; c++) begin
            if (last_g == 0 || !req0) new_req(0);
            else if ($urandom_range(9) == 0) req0 = 1'b0;
            if (last_g == 1 || !req1) new_req(1);
            else if ($urandom_range(9) == 0) req1 = 1'b0;
            step();
        end

        // Drain any ownership left by the random phase.
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
        repeat (2) step();
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

        // Reset asserted in the middle of a port 0 read grant.
        ram[16]   = 32'hCAFE_F00D;
        m_mem[16] = 32'hCAFE_F00D;
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0);
        step();
        check("pre_rst_data", rdata, 32'hCAFE_F00D);
        #2;
        check("pre_rst_gnt0", gnt0, 1'b1);
        reset = 1'b1;
        #1;
        model_reset();
        check("midrst_gnt0", gnt0, 1'b0);
        check("midrst_rvalid0", rvalid0, 1'b0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_mem_we", mem_we, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 1'b1, 1'b0, 32'h48, 32'h0, 4'h0, 1'b0);
        step();
        check("post_rst_first", last_g, 0);
        step();
        check("post_rst_second", last_g, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
